// File: rtl/coco_audio_pkg.sv
// Shared types and constants for the audio / cassette I/O stage.
// Sound source encoding matches the PIA0 {CB2, CA2} mux select pins.
package coco_audio_pkg;

    typedef enum logic [1:0] {
        SRC_DAC  = 2'd0,
        SRC_TAPE = 2'd1,
        SRC_CART = 2'd2,
        SRC_NONE = 2'd3
    } snd_src_t;

    localparam int                 DAC_W        = 6;
    localparam int                 MIX_W        = DAC_W + 1;
    localparam logic [DAC_W-1:0]   MIDSCALE_DEF = 6'h20;
    localparam logic [MIX_W-1:0]   SBS_WEIGHT   = 7'd32;

    // Single-bit sound rides on top of the sampled DAC level, giving 0..95.
    function automatic logic [MIX_W-1:0] mix_level(input logic [DAC_W-1:0] level,
                                                   input logic             sbs);
        return {1'b0, level} + (sbs ? SBS_WEIGHT : {MIX_W{1'b0}});
    endfunction

endpackage

// File: rtl/audio_cassette_io_ds_mod1.sv
// Generic first-order delta-sigma modulator: output is the carry out of a
// W-bit phase accumulator, so ones density = din / 2**W.
module ds_mod1 #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] acc;
    logic [W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, din};

    // clr pins the accumulator at zero so the bit stream restarts from a known phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            dout <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            dout <= 1'b0;
        end else begin
            acc  <= sum[W-1:0];
            dout <= sum[W];
        end
    end

endmodule

// File: rtl/audio_cassette_io.sv
// Audio output and cassette I/O stage behind the two PIAs: sample-rate source
// select, two delta-sigma modulators and a glitch filter on the tape input.
module audio_cassette_io
    import coco_audio_pkg::*;
#(
    parameter int               SAMPLE_DIV = 50,
    parameter int               FILTER_LEN = 16,
    parameter logic [DAC_W-1:0] MIDSCALE   = MIDSCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DAC_W-1:0] dac_in,
    input  logic             sbs,
    input  logic             snd_en,
    input  logic [1:0]       mux_sel,
    input  logic             motor,
    input  logic             tape_in,
    output logic             tape_bit,
    output logic             tape_out,
    output logic             audio,
    output logic             sample_stb
);

    localparam int              DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [DAC_W-1:0] sample_reg;
    logic [DAC_W-1:0] sel_level;
    logic [MIX_W-1:0] mix;
    snd_src_t         src;
    logic             sync_q1;
    logic             sync_q2;
    logic [7:0]       filt_cnt;

    // Sample-rate divider; the strobe is registered from the next count so it
    // is high exactly while div_cnt sits at its last value.
    assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            sample_stb <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            sample_stb <= (div_next == DIV_LAST);
        end
    end

    assign src = snd_src_t'(mux_sel);

    always_comb begin
        sel_level = MIDSCALE;
        if (snd_en) begin
            unique case (src)
                SRC_DAC:  sel_level = dac_in;
                SRC_TAPE: sel_level = tape_bit ? {DAC_W{1'b1}} : {DAC_W{1'b0}};
                SRC_CART: sel_level = MIDSCALE;
                SRC_NONE: sel_level = MIDSCALE;
            endcase
        end
    end

    // tape_bit here is the pre-flip value when a flip lands on the strobe clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg <= MIDSCALE;
        end else if (sample_stb) begin
            sample_reg <= sel_level;
        end
    end

    assign mix = mix_level(sample_reg, sbs);

    ds_mod1 #(.W(MIX_W)) u_audio_mod (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .din  (mix),
        .dout (audio)
    );

    ds_mod1 #(.W(DAC_W)) u_tape_mod (
        .clk  (clk),
        .rst  (rst),
        .clr  (~motor),
        .din  (dac_in),
        .dout (tape_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= tape_in;
            sync_q2 <= sync_q1;
        end
    end

    // Any return to the current level before FILTER_LEN clks restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
            tape_bit <= 1'b0;
        end else if (sync_q2 == tape_bit) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_cnt <= '0;
            tape_bit <= sync_q2;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_audio_cassette_io.sv
// Self-checking bench for audio_cassette_io: vector table of audio densities,
// hand sequences for filter/motor/reset timing, random trials against a model.
module tb_audio_cassette_io;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] dac_in;
    logic       sbs;
    logic       snd_en;
    logic [1:0] mux_sel;
    logic       motor;
    logic       tape_in;
    logic       tape_bit;
    logic       tape_out;
    logic       audio;
    logic       sample_stb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_cassette_io dut (
        .clk        (clk),
        .rst        (rst),
        .dac_in     (dac_in),
        .sbs        (sbs),
        .snd_en     (snd_en),
        .mux_sel    (mux_sel),
        .motor      (motor),
        .tape_in    (tape_in),
        .tape_bit   (tape_bit),
        .tape_out   (tape_out),
        .audio      (audio),
        .sample_stb (sample_stb)
    );

    typedef struct {
        logic [1:0] mux;
        logic       en;
        logic       sbs;
        logic [5:0] dac;
        int         exp_ones;
    } vec_t;

    vec_t vecs[9];

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        check_range(name, act, exp, exp);
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT event", name);
    endtask

    // Reference: the level fed to the audio modulator, from the source rules.
    function automatic int model_mix(input logic [1:0] mux, input logic en, input logic s,
                                     input logic [5:0] dac, input logic tb_lvl);
        int src;
        if (!en) src = 32;
        else begin
            case (mux)
                2'd0:    src = int'(dac);
                2'd1:    src = tb_lvl ? 63 : 0;
                default: src = 32;
            endcase
        end
        return src + (s ? 32 : 0);
    endfunction

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (sample_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait for the strobe that loads the current inputs, then count audio ones.
    task automatic measure_audio(input string name, input int n, output int ones);
        bit ok;
        ones = 0;
        wait_stb(ok);
        if (!ok) report_timeout(name);
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ones += int'(audio);
        end
    endtask

    task automatic count_tape(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ones += int'(tape_out);
        end
    endtask

    task automatic first_strobe(input string name);
        int k;
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (sample_stb) begin
                k = i;
                break;
            end
        end
        if (k == 0) report_timeout(name);
        else check_eq(name, k + 1, 50);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        int k;
        int mx;
        logic tb_lvl;

        vecs[0] = '{2'd0, 1'b1, 1'b0, 6'h30, 480};
        vecs[1] = '{2'd0, 1'b1, 1'b1, 6'h30, 800};
        vecs[2] = '{2'd0, 1'b0, 1'b0, 6'h3F, 320};
        vecs[3] = '{2'd1, 1'b1, 1'b0, 6'h00, 630};
        vecs[4] = '{2'd2, 1'b1, 1'b0, 6'h3F, 320};
        vecs[5] = '{2'd3, 1'b1, 1'b0, 6'h3F, 320};
        vecs[6] = '{2'd0, 1'b1, 1'b1, 6'h3F, 950};
        vecs[7] = '{2'd0, 1'b1, 1'b0, 6'h00, 0};
        vecs[8] = '{2'd1, 1'b0, 1'b1, 6'h3F, 640};

        rst = 1'b1; tape_in = 1'b1; dac_in = 6'h3F; sbs = 1'b1;
        snd_en = 1'b1; mux_sel = 2'd0; motor = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("reset audio", int'(audio), 0);
        check_eq("reset tape_out", int'(tape_out), 0);
        check_eq("reset tape_bit", int'(tape_bit), 0);
        check_eq("reset sample_stb", int'(sample_stb), 0);

        @(negedge clk);
        rst = 1'b0; tape_in = 1'b0; motor = 1'b0; sbs = 1'b0; dac_in = 6'h20;
        first_strobe("first strobe clk");

        count_tape(100, ones);
        check_eq("tape_out motor off", ones, 0);
        @(negedge clk);
        motor = 1'b1;
        @(posedge clk); #1;
        check_eq("tape_out clk1 after motor", int'(tape_out), 0);
        @(posedge clk); #1;
        check_eq("tape_out clk2 after motor", int'(tape_out), 1);
        count_tape(126, ones);
        check_eq("tape_out ones per 128", ones + 1, 64);

        // 10-clk pulse must not pass the filter.
        @(negedge clk); tape_in = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); tape_in = 1'b0;
        ones = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; ones += int'(tape_bit); end
        check_eq("short pulse tape_bit highs", ones, 0);

        @(negedge clk); tape_in = 1'b1;
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (tape_bit) begin k = i; break; end
        end
        if (k == 0) report_timeout("tape_bit rise latency");
        else check_eq("tape_bit rise latency", k, 18);

        @(negedge clk); tape_in = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk); tape_in = 1'b1;
        ones = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; ones += int'(!tape_bit); end
        check_eq("15-clk dropout tape_bit lows", ones, 0);

        @(negedge clk); tape_in = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk); tape_in = 1'b1;
        ones = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; ones += int'(!tape_bit); end
        check_eq("16-clk dropout tape_bit lows", ones, 16);
        tb_lvl = 1'b1;

        for (int v = 0; v < 9; v++) begin
            mux_sel = vecs[v].mux; snd_en = vecs[v].en; sbs = vecs[v].sbs; dac_in = vecs[v].dac;
            measure_audio($sformatf("vec%0d strobe", v), 1280, ones);
            check_range($sformatf("vec%0d audio ones", v), ones, vecs[v].exp_ones - 1, vecs[v].exp_ones + 1);
        end

        // snd_en drop is not seen until the following strobe.
        mux_sel = 2'd0; snd_en = 1'b1; sbs = 1'b0; dac_in = 6'h3F;
        measure_audio("toggle setup", 200, ones);
        begin
            bit ok;
            wait_stb(ok);
            if (!ok) report_timeout("toggle strobe");
        end
        @(posedge clk); #1;
        snd_en = 1'b0;
        ones = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; ones += int'(audio); end
        check_range("snd_en off before strobe", ones, 18, 20);
        measure_audio("toggle after strobe", 1280, ones);
        check_range("snd_en off after strobe", ones, 319, 321);

        for (int t = 0; t < 6; t++) begin
            mux_sel = 2'($urandom_range(0, 3));
            snd_en  = 1'($urandom_range(0, 1));
            sbs     = 1'($urandom_range(0, 1));
            dac_in  = 6'($urandom_range(0, 63));
            mx = model_mix(mux_sel, snd_en, sbs, dac_in, tb_lvl);
            measure_audio($sformatf("rand%0d strobe", t), 1280, ones);
            check_range($sformatf("rand%0d audio mux=%0d en=%0d sbs=%0d dac=%0d", t, mux_sel, snd_en, sbs, dac_in),
                        ones, (mx * 1280) / 128, (mx * 1280 + 127) / 128);
        end

        for (int t = 0; t < 3; t++) begin
            dac_in = 6'($urandom_range(0, 63));
            count_tape(640, ones);
            check_range($sformatf("rand%0d tape_out dac=%0d", t, dac_in),
                        ones, (int'(dac_in) * 640) / 64, (int'(dac_in) * 640 + 63) / 64);
        end

        // Asynchronous reset mid-run with audio busy and tape_bit high.
        mux_sel = 2'd0; snd_en = 1'b1; sbs = 1'b1; dac_in = 6'h3F; motor = 1'b1;
        repeat (120) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("midrun reset audio", int'(audio), 0);
        check_eq("midrun reset tape_out", int'(tape_out), 0);
        check_eq("midrun reset tape_bit", int'(tape_bit), 0);
        check_eq("midrun reset sample_stb", int'(sample_stb), 0);
        @(negedge clk);
        rst = 1'b0; tape_in = 1'b0;
        first_strobe("strobe after midrun reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
